// File: rtl/vd2_scan_ctrl_if.sv
// Handshake and data bundle between the 5:1 mux scan controller and its environment.
// With VD2_SCAN_HOLD_EN defined the bundle also carries the scan hold request.
interface vd2_scan_ctrl_if #(
    parameter int DATA_WIDTH = 3
);
    logic                  start;
    logic                  cont;
    logic                  stop;
`ifdef VD2_SCAN_HOLD_EN
    logic                  hold;
`endif
    logic [DATA_WIDTH-1:0] m_in;
    logic                  s2;
    logic                  s1;
    logic                  s0;
    logic [DATA_WIDTH-1:0] samp_data;
    logic [2:0]            samp_idx;
    logic                  samp_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start, cont, stop, m_in,
`ifdef VD2_SCAN_HOLD_EN
        output hold,
`endif
        input  s2, s1, s0, samp_data, samp_idx, samp_valid, busy, done
    );

    modport slave (
        input  start, cont, stop, m_in,
`ifdef VD2_SCAN_HOLD_EN
        input  hold,
`endif
        output s2, s1, s0, samp_data, samp_idx, samp_valid, busy, done
    );
endinterface

// File: rtl/vd2_scan_ctrl.sv
// Select driver and sample collector for the 5:1 channel mux: dwell, capture, advance.
// Optional VD2_SCAN_HOLD_EN adds a hold input that freezes the scan in place.
module vd2_scan_ctrl #(
    parameter int DATA_WIDTH = 3,
    parameter int DWELL      = 4,
    parameter int NUM_CH     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    vd2_scan_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_CH - 1);

    state_t                state, state_nxt;
    logic [2:0]            idx, idx_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic                  cont_q, cont_nxt;
    logic                  stop_pending, stop_nxt;
    logic [DATA_WIDTH-1:0] samp_data_q, sdata_nxt;
    logic [2:0]            samp_idx_q, sidx_nxt;
    logic                  samp_valid_q, vld_nxt;
    logic                  done_q, done_nxt;
    logic                  adv;

`ifdef VD2_SCAN_HOLD_EN
    assign adv = ~bus.hold;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
            samp_data_q  <= '0;
            samp_idx_q   <= '0;
            samp_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            cont_q       <= cont_nxt;
            stop_pending <= stop_nxt;
            samp_data_q  <= sdata_nxt;
            samp_idx_q   <= sidx_nxt;
            samp_valid_q <= vld_nxt;
            done_q       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        cont_nxt  = cont_q;
        stop_nxt  = stop_pending;
        sdata_nxt = samp_data_q;
        sidx_nxt  = samp_idx_q;
        vld_nxt   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    cont_nxt  = bus.cont;
                    stop_nxt  = 1'b0;
                end
            end
            SCAN: begin
                if (bus.stop) stop_nxt = 1'b1;
                if (adv) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        sdata_nxt = bus.m_in;
                        sidx_nxt  = idx;
                        vld_nxt   = 1'b1;
                        if (idx < IDX_LAST) begin
                            idx_nxt = idx + 3'd1;
                        end else begin
                            idx_nxt = '0;
                            // a stop landing on the last sample still ends this sweep
                            if (!(cont_q && !stop_pending && !bus.stop)) begin
                                done_nxt  = 1'b1;
                                stop_nxt  = 1'b0;
                                state_nxt = IDLE;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        {bus.s2, bus.s1, bus.s0} = idx;
        bus.samp_data  = samp_data_q;
        bus.samp_idx   = samp_idx_q;
        bus.samp_valid = samp_valid_q;
        bus.busy       = (state == SCAN);
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_vd2_scan_ctrl.sv
// Bench for vd2_scan_ctrl: three instances (DWELL 4/2/1) checked every cycle against a
// sweep-timeline model, plus a vector table and directed corner sequences.
module tb_vd2_scan_ctrl;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_v [N];
    logic cont_v  [N];
    logic stop_v  [N];
    logic hold_v  [N];
    logic [2:0] chan_data [N][8];

    wire [2:0] sel_o   [N];
    wire [2:0] sdata_o [N];
    wire [2:0] sidx_o  [N];
    wire       vld_o   [N];
    wire       busy_o  [N];
    wire       done_o  [N];

    for (genvar g = 0; g < N; g++) begin : gd
        vd2_scan_ctrl_if #(.DATA_WIDTH(3)) bus ();
        assign bus.start = start_v[g];
        assign bus.cont  = cont_v[g];
        assign bus.stop  = stop_v[g];
`ifdef VD2_SCAN_HOLD_EN
        assign bus.hold  = hold_v[g];
`endif
        assign bus.m_in   = chan_data[g][{bus.s2, bus.s1, bus.s0}];
        assign sel_o[g]   = {bus.s2, bus.s1, bus.s0};
        assign sdata_o[g] = bus.samp_data;
        assign sidx_o[g]  = bus.samp_idx;
        assign vld_o[g]   = bus.samp_valid;
        assign busy_o[g]  = bus.busy;
        assign done_o[g]  = bus.done;
        vd2_scan_ctrl #(
            .DATA_WIDTH(3),
            .DWELL(g == 0 ? 4 : (g == 1 ? 2 : 1)),
            .NUM_CH(5)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus.slave)
        );
    end

    function automatic int dw(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Model: position p = cycles elapsed in the current sweep (0..5*D-1).
    bit         act    [N];
    int         p      [N];
    bit         cm     [N];
    bit         sm     [N];
    logic       e_vld  [N];
    logic       e_done [N];
    logic [2:0] e_data [N];
    logic [2:0] e_idx  [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = 0; p[i] = 0; cm[i] = 0; sm[i] = 0;
            e_vld[i] = 0; e_done[i] = 0; e_data[i] = '0; e_idx[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int d;
            d = dw(i);
            e_vld[i]  = 0;
            e_done[i] = 0;
            if (!act[i]) begin
                if (start_v[i]) begin
                    act[i] = 1; p[i] = 0; cm[i] = cont_v[i]; sm[i] = 0;
                end
            end else begin
                if (stop_v[i]) sm[i] = 1;
                if (!hold_v[i]) begin
                    p[i]++;
                    if (p[i] % d == 0) begin
                        e_vld[i]  = 1;
                        e_idx[i]  = 3'(p[i] / d - 1);
                        e_data[i] = chan_data[i][p[i] / d - 1];
                        if (p[i] == 5 * d) begin
                            if (cm[i] && !sm[i]) p[i] = 0;
                            else begin
                                act[i] = 0; p[i] = 0; e_done[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("busy%0d", i), 8'(busy_o[i]), 8'(act[i]));
            chk($sformatf("sel%0d", i), 8'(sel_o[i]), act[i] ? 8'(p[i] / dw(i)) : 8'd0);
            chk($sformatf("vld%0d", i), 8'(vld_o[i]), 8'(e_vld[i]));
            chk($sformatf("done%0d", i), 8'(done_o[i]), 8'(e_done[i]));
            chk($sformatf("sdata%0d", i), 8'(sdata_o[i]), 8'(e_data[i]));
            chk($sformatf("sidx%0d", i), 8'(sidx_o[i]), 8'(e_idx[i]));
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        model_check();
    endtask

    task automatic half_b();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        cyc++;
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic clear_in();
        for (int i = 0; i < N; i++) begin
            start_v[i] = 0; cont_v[i] = 0; stop_v[i] = 0; hold_v[i] = 0;
        end
    endtask

    typedef struct {
        int         cyc;
        logic       start;
        logic [2:0] sel;
        logic       vld;
        logic [2:0] data;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int r, nv, dc, fa, dc2;
        int vc [$];
        int exp_vc [5];

        clear_in();
        model_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) chan_data[i][k] = 3'(k + 2);
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        // single sweep, DWELL=4, m_in = idx+2
        tbl[0] = '{0,  1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1,  1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[2] = '{4,  1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[3] = '{5,  1'b0, 3'd1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0};
        tbl[4] = '{9,  1'b0, 3'd2, 1'b1, 3'd3, 3'd1, 1'b1, 1'b0};
        tbl[5] = '{13, 1'b0, 3'd3, 1'b1, 3'd4, 3'd2, 1'b1, 1'b0};
        tbl[6] = '{17, 1'b0, 3'd4, 1'b1, 3'd5, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{20, 1'b0, 3'd4, 1'b0, 3'd5, 3'd3, 1'b1, 1'b0};
        tbl[8] = '{21, 1'b0, 3'd0, 1'b1, 3'd6, 3'd4, 1'b0, 1'b1};
        tbl[9] = '{22, 1'b0, 3'd0, 1'b0, 3'd6, 3'd4, 1'b0, 1'b0};
        r = 0;
        for (int c = 0; c <= 22; c++) begin
            start_v[0] = (r < 10 && tbl[r].cyc == c) ? tbl[r].start : 1'b0;
            half_a();
            if (r < 10 && tbl[r].cyc == c) begin
                chk("tbl_sel",  8'(sel_o[0]),   8'(tbl[r].sel));
                chk("tbl_vld",  8'(vld_o[0]),   8'(tbl[r].vld));
                chk("tbl_data", 8'(sdata_o[0]), 8'(tbl[r].data));
                chk("tbl_idx",  8'(sidx_o[0]),  8'(tbl[r].idx));
                chk("tbl_busy", 8'(busy_o[0]),  8'(tbl[r].busy));
                chk("tbl_done", 8'(done_o[0]),  8'(tbl[r].done));
                r++;
            end
            half_b();
        end
        clear_in();

        // continuous at DWELL=2, stop at cycle 4 -> exactly one sweep
        nv = 0; dc = -1;
        for (int c = 0; c <= 20; c++) begin
            start_v[1] = (c == 0);
            cont_v[1]  = (c == 0);
            stop_v[1]  = (c == 4);
            half_a();
            if (vld_o[1]) nv++;
            if (done_o[1]) dc = c;
            half_b();
        end
        clear_in();
        chk("cs_nsamp", 8'(nv), 8'd5);
        chk("cs_done",  8'(dc), 8'd11);

        // start held through a sweep, then accepted on the done cycle
        nv = 0; dc = -1; fa = -1; dc2 = -1;
        for (int c = 0; c <= 45; c++) begin
            start_v[0] = (c <= 21);
            half_a();
            if (vld_o[0] && c <= 21) nv++;
            if (vld_o[0] && c > 21 && fa < 0) fa = c;
            if (done_o[0] && c <= 21) dc = c;
            if (done_o[0] && c > 21) dc2 = c;
            if (c == 22) chk("b2b_busy", 8'(busy_o[0]), 8'd1);
            if (fa == c) chk("b2b_fidx", 8'(sidx_o[0]), 8'd0);
            half_b();
        end
        clear_in();
        chk("b2b_nsamp", 8'(nv), 8'd5);
        chk("b2b_done1", 8'(dc), 8'd21);
        chk("b2b_first", 8'(fa), 8'd26);
        chk("b2b_done2", 8'(dc2), 8'd42);

        // DWELL=1: select and sample every cycle
        for (int c = 0; c <= 8; c++) begin
            start_v[2] = (c == 0);
            half_a();
            if (c >= 1 && c <= 5) chk("d1_sel", 8'(sel_o[2]), 8'(c - 1));
            chk("d1_vld", 8'(vld_o[2]), 8'(c >= 2 && c <= 6));
            if (c >= 2 && c <= 6) chk("d1_idx", 8'(sidx_o[2]), 8'(c - 2));
            chk("d1_done", 8'(done_o[2]), 8'(c == 6));
            half_b();
        end
        clear_in();

        // asynchronous reset in the middle of a DWELL=4 sweep
        for (int c = 0; c < 7; c++) begin
            start_v[0] = (c == 0);
            tick();
        end
        clear_in();
        chk("rst_pre_busy", 8'(busy_o[0]), 8'd1);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_sel",   8'(sel_o[0]),   8'd0);
        chk("rst_busy",  8'(busy_o[0]),  8'd0);
        chk("rst_vld",   8'(vld_o[0]),   8'd0);
        chk("rst_done",  8'(done_o[0]),  8'd0);
        chk("rst_sdata", 8'(sdata_o[0]), 8'd0);
        tick();
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            half_a();
            if (vld_o[0] || done_o[0] || busy_o[0]) nv++;
            half_b();
        end
        chk("rst_quiet", 8'(nv), 8'd0);

`ifdef VD2_SCAN_HOLD_EN
        // hold three cycles during channel 2
        exp_vc = '{5, 9, 16, 20, 24};
        vc.delete();
        dc = -1;
        for (int c = 0; c <= 27; c++) begin
            start_v[0] = (c == 0);
            hold_v[0]  = (c >= 10 && c <= 12);
            half_a();
            if (c >= 10 && c <= 12) chk("hold_sel", 8'(sel_o[0]), 8'd2);
            if (vld_o[0]) vc.push_back(c);
            if (done_o[0]) dc = c;
            half_b();
        end
        clear_in();
        chk("hold_nsamp", 8'(vc.size()), 8'd5);
        for (int k = 0; k < 5; k++)
            chk("hold_scyc", (k < vc.size()) ? 8'(vc[k]) : 8'hff, 8'(exp_vc[k]));
        chk("hold_done", 8'(dc), 8'd24);
`else
        exp_vc = '{0, 0, 0, 0, 0};
        vc.delete();
`endif

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                start_v[i] = ($urandom_range(5) == 0);
                cont_v[i]  = 1'($urandom);
                stop_v[i]  = ($urandom_range(11) == 0);
`ifdef VD2_SCAN_HOLD_EN
                hold_v[i]  = ($urandom_range(4) == 0);
`endif
                chan_data[i][$urandom_range(7)] = 3'($urandom);
            end
            if ($urandom_range(399) == 0) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        clear_in();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vd2_scan_ctrl.md
Name: vd2_scan_ctrl

Overview:
- Sequential select driver and sample collector for the 5:1 three-bit channel mux (U,V,W,X,Y -> M).
- Steps the mux selects s2,s1,s0 through channels 0..4 and waits a programmable settle time on each.
- Captures the mux output M on each channel and presents it with its channel index and a one-cycle valid strobe.
- Runs either one sweep per start or continuous sweeps until stopped.

Parameters:
- DATA_WIDTH, 3, width of the mux data path (M / m_in / samp_data).
- DWELL, 4, cycles each select value is held before sampling; legal range 1..255.
- NUM_CH, 5, number of channels scanned (indices 0..NUM_CH-1); fixed at 5 for the 5:1 mux.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- cont  input  1  sampled with start; 1 = continuous sweeps, 0 = one sweep.
- stop  input  1  request end of continuous scanning after the current sweep.
- m_in  input  DATA_WIDTH  mux output M fed back.
- s2  output  1  mux select bit 2.
- s1  output  1  mux select bit 1.
- s0  output  1  mux select bit 0.
- samp_data  output  DATA_WIDTH  last captured m_in.
- samp_idx  output  3  channel index of samp_data.
- samp_valid  output  1  one-cycle strobe: new sample.
- busy  output  1  high while scanning.
- done  output  1  one-cycle strobe: sweep sequence finished.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE; {s2,s1,s0}=000 (channel U).
  - samp_data=0, samp_idx=0, samp_valid=0, busy=0, done=0.
  - Dwell counter=0; stop_pending=0; cont latch=0.
- Reset mid-scan aborts immediately; there is no partial done.
- {s2,s1,s0} always equals the registered channel index idx. Values 5..7 are never driven.
- States:
  - IDLE: start=1 -> SCAN with idx=0, cnt=0, busy=1 on the next cycle, cont latched. start=0 -> stay in IDLE.
  - SCAN: cnt increments every cycle. When cnt==DWELL-1:
    - samp_data<=m_in, samp_idx<=idx, samp_valid<=1 (registered; visible next cycle), cnt<=0.
    - If idx<4: idx<=idx+1.
    - If idx==4 and the cont latch=1 and stop_pending=0: idx<=0, continue scanning.
    - If idx==4 otherwise: done<=1, busy<=0, idx<=0, stop_pending<=0 -> IDLE.
- Timing: start sampled at edge 0 -> the sample for channel k is valid in cycle 1+(k+1)*DWELL. One sweep takes 5*DWELL cycles after busy rises.
- On the final sample, done and samp_valid assert in the same cycle.
- samp_valid and done are single-cycle pulses, deasserted otherwise.
- start while busy is ignored. start in the cycle done is high is accepted, giving back-to-back sweeps.
- stop while busy sets stop_pending; it has no effect in IDLE or in one-sweep mode.
- A stop arriving in the same cycle as the idx==4 sample still ends that sweep.
- DWELL=1: a sample every cycle, with select changing every cycle.
- cnt width is 8 bits; it never exceeds DWELL-1.

Optional Feature:
- Macro: VD2_SCAN_HOLD_EN.
- Defined:
  - Adds input hold (1 bit).
  - While hold=1 in SCAN, cnt and idx freeze and no sample or done is produced.
  - Selects stay on the current channel.
  - Scanning resumes where it left off when hold=0.
  - hold has no effect in IDLE.
  - A sample due in a held cycle is deferred until the first unheld cycle at cnt==DWELL-1.
- Not defined: the hold port is absent and the scan never pauses.

Test Plan:
- Reset values: assert rst_n=0 mid-scan at DWELL=4 -> selects=000 and busy/samp_valid/done=0 immediately. After release, no pulses until a new start.
- Single sweep: DWELL=4, cont=0, m_in=idx+2 mirrored by a bench mux model, start at edge 0.
  - samp_valid in cycles 5,9,13,17,21 with samp_data 2,3,4,5,6 and samp_idx 0..4.
  - done=1 and busy=0 in cycle 21.
- Continuous with stop: cont=1, DWELL=2, stop pulsed at cycle 4 -> sweep completes with 5 samples, done in cycle 11, no sixth sample.
- Ignored start / back-to-back: start held high throughout a sweep -> no restart while busy. A new sweep starts from the done cycle, with the first sample DWELL+1 cycles after done.
- Minimum dwell: DWELL=1, cont=0 -> selects 0,1,2,3,4 on consecutive cycles, five consecutive samp_valid cycles, done with the last.
- With VD2_SCAN_HOLD_EN: hold=1 for 3 cycles during channel 2 at DWELL=4 -> selects stay at 010, the channel-2 sample is delayed by exactly 3 cycles, and all later samples shift by 3.
